// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key-matrix front end.
package piano_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 8;
    localparam int NOTE_W   = 5;
    localparam int OCT_W    = 3;
    localparam logic [OCT_W-1:0] OCT_DEFAULT = 3'd4;

    typedef enum logic [1:0] {IDLE, HELD, GAP} key_state_e;

    // hit=0 encodes "no key pressed this frame"
    typedef struct packed {
        logic              hit;
        logic [NOTE_W-1:0] note;
    } key_code_t;

    localparam key_code_t CODE_NONE = '0;
endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw button, debounces it at the frame rate and emits a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iBtn,
    input  logic iTick,
    output logic oRise
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1_q, sync2_q;
    logic          prev_q, lvl_q, rise_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable;

    always_comb begin
        cnt_d = CW'(1);
        if (sync2_q == prev_q)
            cnt_d = (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
    end

    assign stable = (cnt_d == CW'(DEBOUNCE));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= iBtn;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (iTick) begin
                prev_q <= sync2_q;
                cnt_q  <= cnt_d;
                if (stable) begin
                    lvl_q  <= sync2_q;
                    rise_q <= sync2_q & ~lvl_q;
                end
            end
        end
    end

    assign oRise = rise_q;
endmodule

// File: rtl/key_scanner.sv
// Scans the 4x8 key matrix, debounces the first pressed key per frame and
// publishes {octave, note} with a held strobe for the display path.
module key_scanner
    import piano_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 3
) (
    input  logic                iClk,
    input  logic                iRst_n,
    output logic [NUM_COLS-1:0] oCol,
    input  logic [NUM_ROWS-1:0] iRow,
    input  logic                iOctUp,
    input  logic                iOctDn,
    output logic [7:0]          oData,
    output logic                oState
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [DW-1:0]       dwell_q;
    logic [2:0]          col_q;
    logic                tc, frame_end;
    logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
    key_code_t           samp_code, frame_code, acc_q, prev_code_q;
    logic [CW-1:0]       stab_q, stab_d;
    logic                stable;
    key_state_e          state_q, state_d;
    logic [7:0]          data_q, data_d;
    logic                held_q, held_d;
    logic [OCT_W-1:0]    oct_q, oct_d;
    logic                up_rise, dn_rise;

    assign tc        = (dwell_q == DW'(SCAN_DIV - 1));
    assign frame_end = tc && (col_q == 3'd7);
    assign oCol      = ~(8'b1 << col_q);

    // Descending loop so the lowest pressed row in this column wins
    always_comb begin
        samp_code = CODE_NONE;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                samp_code.hit  = 1'b1;
                samp_code.note = {2'(r), col_q};
            end
        end
    end

    assign frame_code = acc_q.hit ? acc_q : samp_code;

    always_comb begin
        stab_d = CW'(1);
        if (frame_code == prev_code_q)
            stab_d = (stab_q == CW'(DEBOUNCE)) ? stab_q : stab_q + 1'b1;
    end

    assign stable = (stab_d == CW'(DEBOUNCE));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        held_d  = held_q;
        if (frame_end && stable) begin
            unique case (state_q)
                IDLE: if (frame_code.hit) begin
                    state_d = HELD;
                    data_d  = {oct_q, frame_code.note};
                    held_d  = 1'b1;
                end
                HELD: if (!frame_code.hit) begin
                    state_d = IDLE;
                    held_d  = 1'b0;
                end else if (frame_code.note != data_q[NOTE_W-1:0]) begin
                    // Drop the strobe for one frame so the old key is latched downstream
                    state_d = GAP;
                    held_d  = 1'b0;
                end
                GAP: if (frame_code.hit) begin
                    state_d = HELD;
                    data_d  = {oct_q, frame_code.note};
                    held_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        oct_d = oct_q;
        if (up_rise && !dn_rise && oct_q != 3'd7)
            oct_d = oct_q + 3'd1;
        else if (dn_rise && !up_rise && oct_q != 3'd0)
            oct_d = oct_q - 3'd1;
    end

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_up (
        .iClk(iClk), .iRst_n(iRst_n), .iBtn(iOctUp), .iTick(frame_end), .oRise(up_rise)
    );
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_dn (
        .iClk(iClk), .iRst_n(iRst_n), .iBtn(iOctDn), .iTick(frame_end), .oRise(dn_rise)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            dwell_q     <= '0;
            col_q       <= 3'd0;
            row_s1_q    <= '1;
            row_s2_q    <= '1;
            acc_q       <= CODE_NONE;
            prev_code_q <= CODE_NONE;
            stab_q      <= '0;
            state_q     <= IDLE;
            data_q      <= {OCT_DEFAULT, 5'd0};
            held_q      <= 1'b0;
            oct_q       <= OCT_DEFAULT;
        end else begin
            row_s1_q <= iRow;
            row_s2_q <= row_s1_q;
            dwell_q  <= tc ? '0 : dwell_q + 1'b1;
            state_q  <= state_d;
            data_q   <= data_d;
            held_q   <= held_d;
            oct_q    <= oct_d;
            if (tc) begin
                col_q <= col_q + 3'd1;
                acc_q <= frame_end ? CODE_NONE : frame_code;
            end
            if (frame_end) begin
                prev_code_q <= frame_code;
                stab_q      <= stab_d;
            end
        end
    end

    assign oData  = data_q;
    assign oState = held_q;
endmodule

// File: tb/tb_key_scanner.sv
// Bench for key_scanner: a step table drives a modelled key matrix and buttons,
// a scoreboard queue holds the expected oState edges with data and cycle.
module tb_key_scanner;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 8 * SD;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic [7:0] oCol;
    logic [3:0] iRow;
    logic       iOctUp = 1'b0;
    logic       iOctDn = 1'b0;
    logic [7:0] oData;
    logic       oState;
    logic [31:0] keys = '0;

    always #5 iClk = ~iClk;

    // Key matrix model: a pressed key pulls its row low while its column is driven
    always_comb begin
        iRow = '1;
        for (int r = 0; r < 4; r++)
            iRow[r] = ~|(keys[r*8 +: 8] & ~oCol);
    end

    key_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .oCol(oCol), .iRow(iRow),
        .iOctUp(iOctUp), .iOctDn(iOctDn), .oData(oData), .oState(oState)
    );

    int total = 0;
    int bad = 0;
    int cyc;

    always @(posedge iClk or negedge iRst_n)
        if (!iRst_n) cyc <= 0;
        else         cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic       st;
        logic [7:0] data;
        int         at;
    } ev_t;
    ev_t sb[$];
    ev_t e;

    logic       mon_en = 1'b0;
    logic       pst;
    logic [7:0] pdat;

    always @(posedge iClk) begin
        #1;
        if (!iRst_n || !mon_en) begin
            pst  = oState;
            pdat = oData;
        end else begin
            if (oState !== pst) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_edge got st=%b data=%0h cyc=%0d", oState, oData, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("edge_state", {31'b0, oState}, {31'b0, e.st});
                    chk("edge_data", {24'b0, oData}, {24'b0, e.data});
                    chk("edge_cycle", cyc, e.at);
                end
            end else if (oData !== pdat) begin
                total++;
                bad++;
                $display("FAIL data_change_without_edge got=%0h was=%0h cyc=%0d", oData, pdat, cyc);
            end
            pst  = oState;
            pdat = oData;
        end
    end

    typedef struct {
        logic [31:0] keys;
        logic        up, dn;
        int          frames;
        int          f0;
        logic        s0;
        logic [7:0]  d0;
        int          f1;
        logic        s1;
        logic [7:0]  d1;
    } step_t;
    step_t steps[$];

    function automatic logic [31:0] K(input int r, input int c);
        logic [31:0] one = 32'd1;
        return one << (r * 8 + c);
    endfunction

    // fN = frame offset of an expected oState edge (0 = none)
    function automatic void add(input logic [31:0] k, input logic up, input logic dn,
                                input int fr, input int f0 = 0, input logic s0 = 1'b0,
                                input logic [7:0] d0 = 8'h0, input int f1 = 0,
                                input logic s1 = 1'b0, input logic [7:0] d1 = 8'h0);
        step_t s;
        s.keys = k; s.up = up; s.dn = dn; s.frames = fr;
        s.f0 = f0; s.s0 = s0; s.d0 = d0; s.f1 = f1; s.s1 = s1; s.d1 = d1;
        steps.push_back(s);
    endfunction

    int         idx_bounce;
    logic [7:0] exp_col;
    ev_t        ne;

    initial begin
        // stimulus table
        add(0, 0, 0, 4);
        for (int i = 0; i < 6; i++) add((i % 2 == 0) ? K(2, 5) : 32'd0, 0, 0, 1);
        add(0, 0, 0, 4);
        idx_bounce = steps.size();
        add(K(2, 5), 0, 0, 10, 3, 1'b1, 8'h95);
        add(0, 0, 0, 10, 3, 1'b0, 8'h95);
        for (int i = 0; i < 5; i++) begin add(0, 1, 0, 4); add(0, 0, 0, 4); end
        add(K(0, 1), 0, 0, 10, 3, 1'b1, 8'hE1);
        add(0, 0, 0, 10, 3, 1'b0, 8'hE1);
        for (int i = 0; i < 9; i++) begin add(0, 0, 1, 4); add(0, 0, 0, 4); end
        add(K(0, 1), 0, 0, 10, 3, 1'b1, 8'h01);
        add(0, 0, 0, 10, 3, 1'b0, 8'h01);
        for (int i = 0; i < 4; i++) begin add(0, 1, 0, 4); add(0, 0, 0, 4); end
        add(K(1, 2) | K(3, 0), 0, 0, 5, 3, 1'b1, 8'h98);
        add(K(0, 7), 0, 0, 10, 3, 1'b0, 8'h98, 4, 1'b1, 8'h87);
        add(0, 0, 0, 10, 3, 1'b0, 8'h87);
        add(K(2, 5), 0, 0, 10, 3, 1'b1, 8'h95);
        add(K(2, 5), 1, 0, 4);
        add(K(2, 5), 0, 0, 4);
        add(0, 0, 0, 10, 3, 1'b0, 8'h95);
        add(K(2, 5), 0, 0, 10, 3, 1'b1, 8'hB5);
        add(0, 0, 0, 10, 3, 1'b0, 8'hB5);
        add(0, 1, 1, 4);
        add(0, 0, 0, 4);
        add(K(0, 0), 0, 0, 10, 3, 1'b1, 8'hA0);
        add(0, 0, 0, 10, 3, 1'b0, 8'hA0);
        add(K(2, 5), 0, 0, 6, 3, 1'b1, 8'hA0 | 8'h15);

        // reset values and column walk
        #12;
        chk("rst_col", {24'b0, oCol}, 32'hFE);
        chk("rst_data", {24'b0, oData}, 32'h80);
        chk("rst_state", {31'b0, oState}, 32'd0);
        @(negedge iClk) iRst_n = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(posedge iClk);
            #1;
            exp_col = ~(8'h01 << ((k / 4) % 8));
            chk("col_walk", {24'b0, oCol}, {24'b0, exp_col});
        end
        // asynchronous reset mid-column
        #3 iRst_n = 1'b0;
        #1;
        chk("midscan_rst_col", {24'b0, oCol}, 32'hFE);
        chk("midscan_rst_data", {24'b0, oData}, 32'h80);
        chk("midscan_rst_state", {31'b0, oState}, 32'd0);
        @(negedge iClk) iRst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < steps.size(); i++) begin
            keys   = steps[i].keys;
            iOctUp = steps[i].up;
            iOctDn = steps[i].dn;
            if (steps[i].f0 != 0) begin
                ne.st = steps[i].s0; ne.data = steps[i].d0; ne.at = cyc + steps[i].f0 * FR;
                sb.push_back(ne);
            end
            if (steps[i].f1 != 0) begin
                ne.st = steps[i].s1; ne.data = steps[i].d1; ne.at = cyc + steps[i].f1 * FR;
                sb.push_back(ne);
            end
            repeat (steps[i].frames * FR) @(posedge iClk);
            #1;
            if (i == idx_bounce - 1) begin
                chk("bounce_state", {31'b0, oState}, 32'd0);
                chk("bounce_data", {24'b0, oData}, 32'h80);
            end
        end

        chk("held_state", {31'b0, oState}, 32'd1);
        chk("held_data", {24'b0, oData}, 32'hB5);
        // asynchronous reset while a key is held
        mon_en = 1'b0;
        #3 iRst_n = 1'b0;
        #1;
        chk("held_rst_state", {31'b0, oState}, 32'd0);
        chk("held_rst_data", {24'b0, oData}, 32'h80);
        chk("held_rst_col", {24'b0, oCol}, 32'hFE);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
